// File: rtl/bird_pkg.sv
// Shared screen geometry and game-life state encoding for the bird motion stage.
package bird_pkg;

  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned BIRD_H   = 32;
  localparam int unsigned START_Y  = 320;
  localparam int unsigned FLOOR_Y  = SCREEN_H - BIRD_H;

  typedef enum logic [1:0] {
    StReady = 2'd0,
    StFly   = 2'd1,
    StDead  = 2'd2
  } bird_state_t;

endpackage

// File: rtl/bird_tick_gen.sv
// Free-running physics tick divider; tick is a registered one-clk pulse every TICK_DIV clocks.
module bird_tick_gen #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q;
  logic            tick_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      if (cnt_q == CntLast) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      tick_q <= (cnt_q == CntLast);
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/bird_physics.sv
// Bird vertical motion: flap synchroniser, READY/FLY/DEAD life FSM and per-tick
// gravity/velocity integration producing the sprite's top-left y coordinate.
module bird_physics
  import bird_pkg::*;
#(
  parameter int unsigned TICK_DIV = 2**19,
  parameter int unsigned FLAP_VEL = 6,
  parameter int unsigned GRAVITY  = 1,
  parameter int unsigned MAX_FALL = 8
) (
  input  logic        clk,
  input  logic        resetGame,
  input  logic        press,
  input  logic        collide,
  output logic [8:0]  y_pos,
  output bird_state_t state,
  output logic        dead,
  output logic        tick
);

  localparam logic signed [5:0]  VelFlap = 6'(-int'(FLAP_VEL));
  localparam logic signed [5:0]  VelGrav = 6'(GRAVITY);
  localparam logic signed [5:0]  VelMax  = 6'(MAX_FALL);
  localparam logic signed [10:0] FloorS  = 11'(FLOOR_Y);

  logic        press_meta_q, press_sync_q, press_prev_q;
  logic        flap_edge;
  bird_state_t state_q, state_d;
  logic        dead_q;
  logic [8:0]  y_q, y_d;
  logic signed [5:0]  vel_q, vel_d;
  logic signed [5:0]  vel_sum, vel_fall, vel_n;
  logic signed [10:0] y_next;
  logic        pend_q, pend_d;

  bird_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk (clk),
    .rst (resetGame),
    .tick(tick)
  );

  assign flap_edge = press_sync_q & ~press_prev_q;

  // A flap seen in the same cycle as the tick update still counts for that update.
  assign vel_sum  = vel_q + VelGrav;
  assign vel_fall = (vel_sum > VelMax) ? VelMax : vel_sum;
  assign vel_n    = (pend_q | flap_edge) ? VelFlap : vel_fall;
  assign y_next   = $signed({2'b00, y_q}) + $signed({{5{vel_n[5]}}, vel_n});

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vel_d   = vel_q;
    pend_d  = pend_q;
    unique case (state_q)
      StReady: begin
        if (flap_edge) begin
          state_d = StFly;
          pend_d  = 1'b1;
        end
      end
      StFly: begin
        if (collide) begin
          state_d = StDead;
        end else if (tick) begin
          pend_d = 1'b0;
          if (y_next <= 0) begin
            y_d   = '0;
            vel_d = '0;
          end else if (y_next >= FloorS) begin
            y_d     = 9'(FLOOR_Y);
            state_d = StDead;
          end else begin
            y_d   = y_next[8:0];
            vel_d = vel_n;
          end
        end else if (flap_edge) begin
          pend_d = 1'b1;
        end
      end
      StDead: begin
      end
      default: begin
        state_d = StReady;
      end
    endcase
  end

  always_ff @(posedge clk or posedge resetGame) begin
    if (resetGame) begin
      press_meta_q <= 1'b0;
      press_sync_q <= 1'b0;
      press_prev_q <= 1'b0;
      state_q      <= StReady;
      dead_q       <= 1'b0;
      y_q          <= 9'(START_Y);
      vel_q        <= '0;
      pend_q       <= 1'b0;
    end else begin
      press_meta_q <= press;
      press_sync_q <= press_meta_q;
      press_prev_q <= press_sync_q;
      state_q      <= state_d;
      dead_q       <= (state_d == StDead);
      y_q          <= y_d;
      vel_q        <= vel_d;
      pend_q       <= pend_d;
    end
  end

  assign y_pos = y_q;
  assign state = state_q;
  assign dead  = dead_q;

endmodule

// File: tb/tb_bird_physics.sv
// Bench for bird_physics: directed tick-aligned vector tables plus randomized press/collide
// traffic checked every clock against an integer game-physics reference model.
module tb_bird_physics;
  import bird_pkg::*;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        resetGame = 1'b1;
  logic        press = 1'b0;
  logic        collide = 1'b0;
  logic [8:0]  y_pos;
  bird_state_t state;
  logic        dead;
  logic        tick;

  bird_physics #(
    .TICK_DIV(TD)
  ) dut (
    .clk      (clk),
    .resetGame(resetGame),
    .press    (press),
    .collide  (collide),
    .y_pos    (y_pos),
    .state    (state),
    .dead     (dead),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: raw press samples per clock edge, game state as plain integers.
  int m_y, m_vel, m_st, m_pend, m_n;
  bit m_samp[$];

  function automatic void model_reset();
    m_y = 320; m_vel = 0; m_st = 0; m_pend = 0; m_n = 0;
    m_samp.delete();
  endfunction

  function automatic bit m_sample(input int k);
    return (k >= 1) ? m_samp[k-1] : 1'b0;
  endfunction

  function automatic void model_edge(input bit p, input bit c);
    bit fl, upd;
    int v, yn;
    m_n++;
    m_samp.push_back(p);
    // A rise sampled at edge k takes effect at edge k+2.
    fl  = m_sample(m_n - 2) && !m_sample(m_n - 3);
    upd = (m_n - 1 > 0) && ((m_n - 1) % TD == 0);
    if (m_st == 0) begin
      if (fl) begin m_st = 1; m_pend = 1; end
    end else if (m_st == 1) begin
      if (c) m_st = 2;
      else if (upd) begin
        v = (m_pend != 0 || fl) ? -6 : ((m_vel + 1 > 8) ? 8 : m_vel + 1);
        m_pend = 0;
        yn = m_y + v;
        if (yn <= 0) begin m_y = 0; m_vel = 0; end
        else if (yn >= 448) begin m_y = 448; m_st = 2; end
        else begin m_y = yn; m_vel = v; end
      end else if (fl) m_pend = 1;
    end
  endfunction

  task automatic check_model();
    chk("model y_pos", int'(y_pos), m_y);
    chk("model state", int'(state), m_st);
    chk("model dead", int'(dead), int'(m_st == 2));
    chk("model tick", int'(tick), int'(m_n > 0 && m_n % TD == 0));
  endtask

  task automatic step(input logic p, input logic c);
    press = p;
    collide = c;
    @(posedge clk);
    model_edge(p, c);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    resetGame = 1'b1;
    press = 1'b0;
    collide = 1'b0;
    @(posedge clk);
    #1;
    resetGame = 1'b0;
    model_reset();
  endtask

  // One row spans one tick period; its last edge is the physics update edge.
  typedef struct {
    logic [3:0] p;
    logic [3:0] c;
    int         exp_y;
    int         exp_st;
  } row_t;

  task automatic run_row(input string name, input row_t r);
    for (int j = 3; j >= 0; j--) step(r.p[j], r.c[j]);
    chk({name, " y_pos"}, int'(y_pos), r.exp_y);
    chk({name, " state"}, int'(state), r.exp_st);
  endtask

  row_t t2[11];
  row_t t5[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int tc, y, v;
    bit p, c, floored;
    int rate;
    row_t r;

    t2 = '{
      '{4'b1000, 4'b0000, 314, 1}, '{4'b0000, 4'b0000, 309, 1},
      '{4'b0000, 4'b0000, 305, 1}, '{4'b0000, 4'b0000, 302, 1},
      '{4'b0000, 4'b0000, 300, 1}, '{4'b0000, 4'b0000, 299, 1},
      '{4'b0000, 4'b0000, 299, 1}, '{4'b0001, 4'b0000, 300, 1},
      '{4'b0100, 4'b0000, 294, 1}, '{4'b0000, 4'b0000, 289, 1},
      '{4'b0000, 4'b0000, 285, 1}
    };
    t5 = '{
      '{4'b0000, 4'b1111, 320, 0}, '{4'b1000, 4'b0000, 314, 1},
      '{4'b0000, 4'b0000, 309, 1}, '{4'b0000, 4'b0000, 305, 1},
      '{4'b0000, 4'b0000, 302, 1}, '{4'b0000, 4'b0000, 300, 1},
      '{4'b0000, 4'b0001, 300, 2}, '{4'b1000, 4'b0000, 300, 2},
      '{4'b0100, 4'b1111, 300, 2}
    };

    // Idle in READY: y held, tick every 4 clocks.
    do_reset();
    chk("reset y_pos", int'(y_pos), 320);
    chk("reset state", int'(state), 0);
    chk("reset dead", int'(dead), 0);
    chk("reset tick", int'(tick), 0);
    tc = 0;
    for (int i = 1; i <= 20 * TD; i++) begin
      step(1'b0, 1'b0);
      chk("tick period", int'(tick), int'(i % 4 == 0));
      if (tick) tc++;
    end
    chk("tick count", tc, 20);
    chk("ready y_pos", int'(y_pos), 320);
    chk("ready state", int'(state), 0);
    chk("ready dead", int'(dead), 0);

    // Flap arc, then a double press within one tick giving a single flap.
    do_reset();
    step(1'b0, 1'b0);
    foreach (t2[i]) run_row("flap arc", t2[i]);

    // Free fall with capped velocity down to the floor.
    y = 285; v = -4; floored = 0;
    for (int i = 0; i < 100 && !floored; i++) begin
      v = (v + 1 > 8) ? 8 : v + 1;
      y = y + v;
      if (y >= 448) begin
        floored = 1;
        y = 448;
      end
      r = '{4'b0000, 4'b0000, y, floored ? 2 : 1};
      run_row("fall", r);
    end
    chk("floor reached", int'(floored), 1);
    for (int i = 0; i < 3; i++) run_row("dead hold", '{4'b1000, 4'b0000, 448, 2});
    chk("floor dead", int'(dead), 1);

    // Flap every tick into the ceiling.
    do_reset();
    step(1'b0, 1'b0);
    y = 320;
    for (int i = 0; i < 58; i++) begin
      y = (y - 6 <= 0) ? 0 : y - 6;
      run_row("ceiling", '{4'b1000, 4'b0000, y, 1});
    end
    run_row("ceiling vel zero", '{4'b0000, 4'b0000, 1, 1});
    chk("ceiling dead", int'(dead), 0);

    // Collide coinciding with a tick update; DEAD then frozen.
    do_reset();
    step(1'b0, 1'b0);
    foreach (t5[i]) run_row("collide", t5[i]);
    chk("collide dead", int'(dead), 1);

    // Asynchronous reset mid-flight, then full press latency.
    do_reset();
    step(1'b0, 1'b0);
    run_row("pre-reset", '{4'b1000, 4'b0000, 314, 1});
    run_row("pre-reset", '{4'b0000, 4'b0000, 309, 1});
    step(1'b0, 1'b0);
    #3;
    resetGame = 1'b1;
    #1;
    chk("async reset y_pos", int'(y_pos), 320);
    chk("async reset state", int'(state), 0);
    chk("async reset dead", int'(dead), 0);
    chk("async reset tick", int'(tick), 0);
    #2;
    resetGame = 1'b0;
    model_reset();
    press = 1'b1;
    @(posedge clk);
    model_edge(1'b1, 1'b0);
    #1;
    check_model();
    chk("latency edge1 state", int'(state), 0);
    step(1'b1, 1'b0);
    chk("latency edge2 state", int'(state), 0);
    step(1'b0, 1'b0);
    chk("latency edge3 state", int'(state), 1);

    // Randomized traffic against the model.
    do_reset();
    p = 0;
    for (int seg = 0; seg < 12; seg++) begin
      rate = $urandom_range(2, 16);
      for (int i = 0; i < 100; i++) begin
        if ($urandom_range(0, rate - 1) == 0) p = ~p;
        c = ($urandom_range(0, 149) == 0);
        if ($urandom_range(0, 299) == 0) begin
          do_reset();
          p = 0;
        end
        step(p, c);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
